// File: rtl/step_pulse_conditioner.sv
// +----------------------------------------------------------------------------+
// | step_pulse_conditioner: debounced single-cycle step strobe, auto-run mode, |
// | and a 16-bit step counter.                         Revision: 1.0 initial   |
// +----------------------------------------------------------------------------+
`default_nettype none

module step_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_PERIOD      = 25000000,
    parameter int CNT_W           = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PushButton,
    input  logic        run,
    output logic        step,
    output logic        btnLevel,
    output logic [15:0] stepCount
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_PERIOD - 1);

    state_t             state_q, state_d;
    logic [1:0]         btn_sync_q, run_sync_q;
    logic [CNT_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic               step_q, step_d;
    logic               btn_level_q, btn_level_d;
    logic [15:0]        step_count_q, step_count_d;
    logic               btn_s, run_s;
    logic               press_accept, auto_fire;

    assign btn_s = btn_sync_q[1];
    assign run_s = run_sync_q[1];

    always_comb begin
        state_d      = state_q;
        deb_cnt_d    = deb_cnt_q;
        press_accept = 1'b0;
        case (state_q)
            IDLE: begin
                deb_cnt_d = '0;
                if (btn_s) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d      = HELD;
                    deb_cnt_d    = '0;
                    press_accept = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                deb_cnt_d = '0;
                if (!btn_s) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d   = HELD;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                deb_cnt_d = '0;
            end
        endcase
    end

    // Period counter sits at zero whenever auto-run is off, so a partial period is discarded.
    always_comb begin
        auto_fire = run_s && (run_cnt_q == RUN_LAST);
        if (!run_s || auto_fire) run_cnt_d = '0;
        else                     run_cnt_d = run_cnt_q + CNT_W'(1);
        step_d       = auto_fire | (press_accept & ~run_s);
        btn_level_d  = (state_d == HELD) || (state_d == RELEASE_WAIT);
        step_count_d = step_count_q + 16'(step_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_sync_q   <= '0;
            run_sync_q   <= '0;
            state_q      <= IDLE;
            deb_cnt_q    <= '0;
            run_cnt_q    <= '0;
            step_q       <= 1'b0;
            btn_level_q  <= 1'b0;
            step_count_q <= '0;
        end else begin
            btn_sync_q   <= {btn_sync_q[0], PushButton};
            run_sync_q   <= {run_sync_q[0], run};
            state_q      <= state_d;
            deb_cnt_q    <= deb_cnt_d;
            run_cnt_q    <= run_cnt_d;
            step_q       <= step_d;
            btn_level_q  <= btn_level_d;
            step_count_q <= step_count_d;
        end
    end

    assign step      = step_q;
    assign btnLevel  = btn_level_q;
    assign stepCount = step_count_q;

endmodule

`default_nettype wire

// File: tb/tb_step_pulse_conditioner.sv
// +----------------------------------------------------------------------------+
// | tb_step_pulse_conditioner: directed bench, DEBOUNCE_CYCLES=4, RUN_PERIOD=8. |
// | Revision: 1.0 initial                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_step_pulse_conditioner;

    logic        clk = 1'b0;
    logic        reset;
    logic        PushButton;
    logic        run;
    logic        step;
    logic        btnLevel;
    logic [15:0] stepCount;

    int n_pass  = 0;
    int n_total = 0;
    int lat;
    int cnt;
    int falls;
    logic prev_lvl;

    step_pulse_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .RUN_PERIOD      (8),
        .CNT_W           (25)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PushButton (PushButton),
        .run        (run),
        .step       (step),
        .btnLevel   (btnLevel),
        .stepCount  (stepCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns number of rising edges until step is seen high; 0 if never.
    task automatic wait_step(input int max_c, output int l);
        l = 0;
        for (int i = 1; i <= max_c; i++) begin
            @(negedge clk);
            if (step === 1'b1) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic count_steps(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (step === 1'b1) c++;
        end
    endtask

    initial begin
        reset = 1'b1; PushButton = 1'b0; run = 1'b0;
        cyc(3);
        chk("reset_step", 32'(step), 32'd0);
        chk("reset_btnLevel", 32'(btnLevel), 32'd0);
        chk("reset_stepCount", 32'(stepCount), 32'd0);
        reset = 1'b0;
        cyc(3);

        // Clean press
        PushButton = 1'b1;
        wait_step(20, lat);
        chk("clean_latency", 32'(lat), 32'd7);
        count_steps(12, cnt);
        chk("clean_no_repeat", 32'(cnt), 32'd0);
        chk("clean_btnLevel", 32'(btnLevel), 32'd1);
        chk("clean_stepCount", 32'(stepCount), 32'd1);

        // Clean release: level drops exactly 7 edges later
        PushButton = 1'b0;
        cyc(6);
        chk("release_level_6", 32'(btnLevel), 32'd1);
        cyc(1);
        chk("release_level_7", 32'(btnLevel), 32'd0);
        cyc(4);

        // Bouncing press
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            PushButton = (i % 2 == 0);
            @(negedge clk);
            if (step === 1'b1) cnt++;
        end
        PushButton = 1'b1;
        wait_step(20, lat);
        chk("bounce_latency", 32'(lat), 32'd7);
        chk("bounce_stepCount", 32'(stepCount), 32'd2);
        chk("bounce_early_steps", 32'(cnt), 32'd0);
        cyc(4);

        // Bouncing release
        cnt = 0; falls = 0; prev_lvl = btnLevel;
        for (int i = 0; i < 24; i++) begin
            PushButton = (i < 4) ? (i % 2 == 1) : 1'b0;
            @(negedge clk);
            if (step === 1'b1) cnt++;
            if (prev_lvl === 1'b1 && btnLevel === 1'b0) falls++;
            prev_lvl = btnLevel;
        end
        chk("rel_bounce_steps", 32'(cnt), 32'd0);
        chk("rel_bounce_falls", 32'(falls), 32'd1);
        chk("rel_bounce_level", 32'(btnLevel), 32'd0);

        // Auto-run: first step 2 sync + 8 period edges after raw run rises
        run = 1'b1;
        wait_step(20, lat);
        chk("auto_first_latency", 32'(lat), 32'd10);
        count_steps(24, cnt);
        chk("auto_next_three", 32'(cnt), 32'd3);
        PushButton = 1'b1;
        count_steps(12, cnt);
        chk("auto_press_steps", 32'(cnt), 32'd1);
        chk("auto_press_btnLevel", 32'(btnLevel), 32'd1);
        chk("auto_stepCount", 32'(stepCount), 32'd7);

        // Run falls mid-period: partial period dropped, release gives no step
        run = 1'b0; PushButton = 1'b0;
        count_steps(12, cnt);
        chk("run_fall_steps", 32'(cnt), 32'd0);
        chk("run_fall_btnLevel", 32'(btnLevel), 32'd0);
        chk("run_fall_stepCount", 32'(stepCount), 32'd7);

        run = 1'b1;
        wait_step(20, lat);
        chk("rerun_full_period", 32'(lat), 32'd10);
        chk("rerun_stepCount", 32'(stepCount), 32'd8);
        run = 1'b0;
        cyc(6);

        // Manual press after run mode
        PushButton = 1'b1;
        wait_step(20, lat);
        chk("manual_after_run", 32'(lat), 32'd7);
        chk("manual_stepCount", 32'(stepCount), 32'd9);

        // Reset while in PRESS_WAIT
        PushButton = 1'b0;
        cyc(10);
        chk("pre_reset_level", 32'(btnLevel), 32'd0);
        PushButton = 1'b1;
        cyc(4);
        reset = 1'b1;
        cyc(1);
        chk("rst_pw_step", 32'(step), 32'd0);
        chk("rst_pw_btnLevel", 32'(btnLevel), 32'd0);
        chk("rst_pw_stepCount", 32'(stepCount), 32'd0);
        reset = 1'b0;
        wait_step(20, lat);
        chk("rst_pw_relatency", 32'(lat), 32'd7);
        chk("rst_pw_recount", 32'(stepCount), 32'd1);

        // Reset during the step pulse cycle
        PushButton = 1'b0;
        cyc(10);
        PushButton = 1'b1;
        wait_step(20, lat);
        chk("pulse_latency", 32'(lat), 32'd7);
        chk("pulse_stepCount", 32'(stepCount), 32'd2);
        reset = 1'b1;
        cyc(1);
        chk("rst_pulse_step", 32'(step), 32'd0);
        chk("rst_pulse_btnLevel", 32'(btnLevel), 32'd0);
        chk("rst_pulse_stepCount", 32'(stepCount), 32'd0);
        reset = 1'b0;
        wait_step(20, lat);
        chk("rst_pulse_relatency", 32'(lat), 32'd7);
        chk("rst_pulse_recount", 32'(stepCount), 32'd1);

        // Counter wrap from 16'hFFFF
        force dut.step_count_q = 16'hFFFF;
        #1;
        release dut.step_count_q;
        chk("wrap_preload", 32'(stepCount), 32'h0000_FFFF);
        run = 1'b1;
        wait_step(20, lat);
        chk("wrap_latency", 32'(lat), 32'd10);
        chk("wrap_stepCount", 32'(stepCount), 32'd0);
        run = 1'b0;
        cyc(1);
        chk("wrap_step_low", 32'(step), 32'd0);
        cyc(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/step_pulse_conditioner.md
Name: step_pulse_conditioner

Overview:
- Conditions the raw board pushbutton into a clean, debounced, single-cycle step strobe for the single-cycle processor.
- Also offers an auto-run mode that issues periodic steps.
- Keeps a 16-bit count of issued steps so the display path can show it.
- Sits upstream of the processor's clock/enable input, on the fast board clock domain.

Parameters:
- DEBOUNCE_CYCLES, 500000: number of consecutive stable samples required before an input change is accepted (5 ms at 100 MHz).
- RUN_PERIOD, 25000000: clk cycles between auto-run steps (4 Hz at 100 MHz).
- CNT_W, 25: width of the internal counters; must hold max(DEBOUNCE_CYCLES, RUN_PERIOD).

Ports:
- clk  input  1  board clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- PushButton  input  1  raw, asynchronous, bouncing button.
- run  input  1  level; 1 selects auto-run mode (slide switch, asynchronous).
- step  output  1  one-clk-cycle step strobe to the processor.
- btnLevel  output  1  debounced button level.
- stepCount  output  16  number of step strobes issued since reset.

Behaviour:
- Synchronisers: PushButton and run each pass through a 2-flop synchroniser (2-cycle latency) before any other logic; the fabric uses only the synchronised values.
- Reset (clk edge with reset=1): FSM=IDLE, counters=0, step=0, btnLevel=0, stepCount=0, synchroniser flops=0.
- Debounce FSM states:
  - IDLE: btnLevel=0. Synced button=1 -> PRESS_WAIT, debounce counter cleared.
  - PRESS_WAIT: counter increments each cycle the synced button=1. Synced button=0 -> IDLE. Counter reaching DEBOUNCE_CYCLES-1 while button=1 -> HELD.
  - HELD: btnLevel=1. Synced button=0 -> RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: btnLevel=1. Counter increments each cycle the synced button=0. Synced button=1 -> HELD. Counter reaching DEBOUNCE_CYCLES-1 while button=0 -> IDLE.
  - btnLevel is a registered decode of state.
- Manual step: the PRESS_WAIT->HELD transition pulses step=1 for exactly the following cycle, only if synced run=0. Press-to-step latency = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles. Holding the button never repeats the step. One step per accepted press.
- Auto-run: while synced run=1, the period counter increments every cycle. At RUN_PERIOD-1 it wraps to 0 and step pulses for one cycle. While run=0 the period counter is held at 0, so the first auto step occurs RUN_PERIOD cycles after synced run rises.
- Mode interaction:
  - While run=1, manual presses are still debounced (btnLevel tracks) but generate no step.
  - run falling mid-period discards the partial period.
  - A press accepted in the same cycle run falls: run is sampled in that cycle; run=0 -> step issued.
  - Never more than one step per cycle; step is never high on two consecutive cycles.
- stepCount increments by 1 in the cycle step is registered high. Modulo 2^16: 16'hFFFF -> 16'h0000, no saturation, no flag.
- Reset mid-operation (any state, mid-pulse): the next edge forces the full reset values. An in-flight step pulse is cancelled and not counted. A button still held after reset is released must be debounced afresh (re-enters via IDLE -> PRESS_WAIT).
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan (DEBOUNCE_CYCLES=4, RUN_PERIOD=8):
- Clean press: reset, PushButton 0->1 held 20 cycles, run=0 -> exactly one step pulse, 7 cycles after the press edge (2 sync + 4 debounce + 1). btnLevel=1. stepCount=1.
- Bounce: PushButton toggles 1,0,1,0 each cycle, then holds 1 -> no step during the bounce. Exactly one step 7 cycles after the final rising edge. Release with bounce -> btnLevel falls once, no step.
- Auto-run: run=1 held 40 cycles -> step pulses every 8 cycles. The first pulse comes 8 cycles after synced run rises, 4 pulses in total. A press during auto-run gives btnLevel=1 but no extra step. stepCount=4.
- Wrap: preload via 65535 auto steps (or force) so stepCount=16'hFFFF, then one more step -> stepCount=16'h0000.
- Reset mid-op: assert reset in PRESS_WAIT and in the step-pulse cycle -> next edge gives step=0, btnLevel=0, stepCount=0. Button still held after deassert -> a new step 7 cycles later.
- Mode switch: run 1->0 at period count 5 -> no step emitted. A subsequent manual press steps normally.
